// File: rtl/cp0_interrupt_unit.sv
// Coprocessor-0 responder: MFC0/MTC0/ERET execution, external interrupt
// synchronisation, pending latch and PC redirect for handler entry/return.
module cp0_interrupt_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] EHBR_RST = ADDR_W'(32'h0000_0100)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cp_oper,
   input  logic              exe_valid,
   input  logic [4:0]        addr_r,
   output logic [31:0]       data_r,
   input  logic [4:0]        addr_w,
   input  logic [31:0]       data_w,
   input  logic [ADDR_W-1:0] ret_addr,
   input  logic              ir_en,
   input  logic              ir_in,
   output logic              jump_en,
   output logic [ADDR_W-1:0] jump_addr,
   output logic              ir_active
);

   localparam logic [1:0] OP_MTC0 = 2'd2;
   localparam logic [1:0] OP_ERET = 2'd3;

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;
   localparam logic [4:0] REG_EHBR   = 5'd25;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_TAKE    = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;
   localparam logic [1:0] S_RET     = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              sync1_q, sync2_q, sync3_q;
   logic              pending_q, pending_d;
   logic              ie_q, ie_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [ADDR_W-1:0] ehbr_q, ehbr_d;
   logic              jump_en_q, jump_en_d;
   logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
   logic              ir_active_q, ir_active_d;

   logic req;
   logic mtc0;
   logic eret;

   assign req  = sync2_q & ~sync3_q;
   assign mtc0 = exe_valid & (cp_oper == OP_MTC0);
   assign eret = exe_valid & (cp_oper == OP_ERET);

   assign jump_en   = jump_en_q;
   assign jump_addr = jump_addr_q;
   assign ir_active = ir_active_q;

   // Read port returns pre-write values, so same-cycle MFC0/MTC0 sees the old data
   always_comb begin
      data_r = 32'd0;
      case (addr_r)
         REG_STATUS: data_r = {31'd0, ie_q};
         REG_CAUSE:  data_r = {pending_q, 31'd0};
         REG_EPC:    data_r = 32'(epc_q);
         REG_EHBR:   data_r = 32'(ehbr_q);
         default:    data_r = 32'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q | req;
      ie_d        = ie_q;
      epc_d       = epc_q;
      ehbr_d      = ehbr_q;
      jump_en_d   = 1'b0;
      jump_addr_d = jump_addr_q;

      if (mtc0) begin
         case (addr_w)
            REG_STATUS: ie_d   = data_w[0];
            REG_EPC:    epc_d  = ADDR_W'(data_w);
            REG_EHBR:   ehbr_d = ADDR_W'(data_w);
            default:    ;
         endcase
      end

      // ERET is decoded ahead of entry so it wins a same-cycle contest
      case (state_q)
         S_IDLE: begin
            if (eret) begin
               jump_en_d   = 1'b1;
               jump_addr_d = epc_q;
            end else if (pending_q && ie_q && ir_en && exe_valid) begin
               state_d     = S_TAKE;
               epc_d       = ret_addr;
               pending_d   = req;
               jump_en_d   = 1'b1;
               jump_addr_d = ehbr_q;
            end
         end
         S_TAKE: state_d = S_SERVICE;
         S_SERVICE: begin
            if (eret) begin
               state_d     = S_RET;
               jump_en_d   = 1'b1;
               jump_addr_d = epc_q;
            end
         end
         S_RET:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      ir_active_d = (state_d == S_SERVICE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
         pending_q   <= 1'b0;
         ie_q        <= 1'b0;
         epc_q       <= '0;
         ehbr_q      <= EHBR_RST;
         jump_en_q   <= 1'b0;
         jump_addr_q <= '0;
         ir_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= ir_in;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
         pending_q   <= pending_d;
         ie_q        <= ie_d;
         epc_q       <= epc_d;
         ehbr_q      <= ehbr_d;
         jump_en_q   <= jump_en_d;
         jump_addr_q <= jump_addr_d;
         ir_active_q <= ir_active_d;
      end
   end

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Directed bench for cp0_interrupt_unit: register access, interrupt entry,
// deferral, ERET priority and reset while in service.
module tb_cp0_interrupt_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  cp_oper;
   logic        exe_valid;
   logic [4:0]  addr_r;
   logic [31:0] data_r;
   logic [4:0]  addr_w;
   logic [31:0] data_w;
   logic [31:0] ret_addr;
   logic        ir_en;
   logic        ir_in;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        ir_active;

   int total = 0;
   int bad   = 0;

   cp0_interrupt_unit dut (
      .clk(clk), .rst(rst), .cp_oper(cp_oper), .exe_valid(exe_valid),
      .addr_r(addr_r), .data_r(data_r), .addr_w(addr_w), .data_w(data_w),
      .ret_addr(ret_addr), .ir_en(ir_en), .ir_in(ir_in),
      .jump_en(jump_en), .jump_addr(jump_addr), .ir_active(ir_active)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      cp_oper = 2'd2; exe_valid = 1'b1; addr_w = a; data_w = d;
      tick();
      cp_oper = 2'd0; exe_valid = 1'b0;
   endtask

   task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
      addr_r = a;
      #1;
      d = data_r;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1'b1; cp_oper = 2'd0; exe_valid = 1'b0; addr_r = 5'd0; addr_w = 5'd0;
      data_w = 32'd0; ret_addr = 32'd0; ir_en = 1'b0; ir_in = 1'b0;
      tick(); tick();
      rst = 1'b0;
      total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL reset_jump_en got=%b exp=0", jump_en); end
      total++; if (jump_addr !== 32'd0) begin bad++; $display("FAIL reset_jump_addr got=%h exp=0", jump_addr); end
      total++; if (ir_active !== 1'b0) begin bad++; $display("FAIL reset_ir_active got=%b exp=0", ir_active); end
      read_reg(5'd25, v);
      total++; if (v !== 32'h0000_0100) begin bad++; $display("FAIL reset_ehbr got=%h exp=00000100", v); end
      read_reg(5'd12, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_status got=%h exp=0", v); end
      read_reg(5'd14, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_epc got=%h exp=0", v); end
   endtask

   task automatic test_cp0_rw();
      logic [31:0] v;
      mtc0(5'd12, 32'hFFFF_FFFF);
      read_reg(5'd12, v);
      total++; if (v !== 32'd1) begin bad++; $display("FAIL status_mask got=%h exp=1", v); end
      mtc0(5'd25, 32'h0000_0200);
      read_reg(5'd25, v);
      total++; if (v !== 32'h0000_0200) begin bad++; $display("FAIL mfc0_ehbr got=%h exp=200", v); end
      mtc0(5'd5, 32'hDEAD_BEEF);
      read_reg(5'd5, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", v); end
      // MTC0 with exe_valid low is a bubble and must not write
      cp_oper = 2'd2; exe_valid = 1'b0; addr_w = 5'd25; data_w = 32'h0000_0999;
      tick();
      cp_oper = 2'd0;
      read_reg(5'd25, v);
      total++; if (v !== 32'h0000_0200) begin bad++; $display("FAIL bubble_write got=%h exp=200", v); end
      // same-cycle MFC0/MTC0 on one index sees the old value
      cp_oper = 2'd2; exe_valid = 1'b1; addr_w = 5'd25; data_w = 32'h0000_0300; addr_r = 5'd25;
      #1;
      total++; if (data_r !== 32'h0000_0200) begin bad++; $display("FAIL rw_same_cycle got=%h exp=200", data_r); end
      tick();
      total++; if (data_r !== 32'h0000_0300) begin bad++; $display("FAIL rw_after_edge got=%h exp=300", data_r); end
      cp_oper = 2'd0; exe_valid = 1'b0;
      mtc0(5'd25, 32'h0000_0200);
      mtc0(5'd12, 32'd1);
   endtask

   task automatic test_entry();
      logic [31:0] v;
      ir_en = 1'b1; exe_valid = 1'b1; cp_oper = 2'd0; ret_addr = 32'h40; ir_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL entry_early cyc=%0d got=%b exp=0", i, jump_en); end
      end
      tick();
      total++; if (jump_en !== 1'b1) begin bad++; $display("FAIL entry_jump_en got=%b exp=1", jump_en); end
      total++; if (jump_addr !== 32'h200) begin bad++; $display("FAIL entry_jump_addr got=%h exp=200", jump_addr); end
      tick();
      total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL entry_pulse_width got=%b exp=0", jump_en); end
      total++; if (ir_active !== 1'b1) begin bad++; $display("FAIL entry_ir_active got=%b exp=1", ir_active); end
      read_reg(5'd14, v);
      total++; if (v !== 32'h40) begin bad++; $display("FAIL entry_epc got=%h exp=40", v); end
   endtask

   task automatic test_nested_and_eret();
      logic [31:0] v;
      ir_in = 1'b0;
      tick(); tick(); tick();
      ir_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (jump_en !== 1'b0 || ir_active !== 1'b1) begin
            bad++; $display("FAIL no_nesting cyc=%0d jump_en=%b ir_active=%b exp 0/1", i, jump_en, ir_active);
         end
      end
      read_reg(5'd13, v);
      total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL cause_pending got=%h exp=80000000", v); end
      ret_addr = 32'h80; cp_oper = 2'd3;
      tick();
      cp_oper = 2'd0;
      total++; if (jump_en !== 1'b1 || jump_addr !== 32'h40) begin
         bad++; $display("FAIL eret_redirect jump_en=%b addr=%h exp 1/40", jump_en, jump_addr);
      end
      total++; if (ir_active !== 1'b0) begin bad++; $display("FAIL eret_ir_active got=%b exp=0", ir_active); end
      tick();
      total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL ret_idle_gap got=%b exp=0", jump_en); end
      tick();
      total++; if (jump_en !== 1'b1 || jump_addr !== 32'h200) begin
         bad++; $display("FAIL pending_retaken jump_en=%b addr=%h exp 1/200", jump_en, jump_addr);
      end
      read_reg(5'd14, v);
      total++; if (v !== 32'h80) begin bad++; $display("FAIL retaken_epc got=%h exp=80", v); end
      tick();
      cp_oper = 2'd3;
      tick();
      cp_oper = 2'd0;
      total++; if (jump_addr !== 32'h80) begin bad++; $display("FAIL eret2_addr got=%h exp=80", jump_addr); end
      tick();
      // ir_in is still held high: the level must not raise another request
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL level_single_req cyc=%0d got=%b exp=0", i, jump_en); end
      end
      read_reg(5'd13, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL level_no_pending got=%h exp=0", v); end
      ir_in = 1'b0;
   endtask

   task automatic test_defer();
      logic [31:0] v;
      ir_en = 1'b0; exe_valid = 1'b1; cp_oper = 2'd0;
      tick(); tick(); tick();
      ir_in = 1'b1; ret_addr = 32'h60;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL defer_ir_en cyc=%0d got=%b exp=0", i, jump_en); end
      end
      read_reg(5'd13, v);
      total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL defer_pending got=%h exp=80000000", v); end
      ir_en = 1'b1; exe_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL defer_bubble cyc=%0d got=%b exp=0", i, jump_en); end
      end
      exe_valid = 1'b1; ret_addr = 32'h64;
      tick();
      total++; if (jump_en !== 1'b1 || jump_addr !== 32'h200) begin
         bad++; $display("FAIL defer_entry jump_en=%b addr=%h exp 1/200", jump_en, jump_addr);
      end
      tick();
      read_reg(5'd14, v);
      total++; if (v !== 32'h64) begin bad++; $display("FAIL defer_epc got=%h exp=64", v); end
      cp_oper = 2'd3; tick(); cp_oper = 2'd0; tick();
      ir_in = 1'b0;
   endtask

   task automatic test_ie_clear();
      logic [31:0] v;
      ir_en = 1'b0;
      mtc0(5'd12, 32'd0);
      tick(); tick();
      ir_in = 1'b1;
      tick(); tick(); tick(); tick();
      ir_en = 1'b1; exe_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL ie_masked cyc=%0d got=%b exp=0", i, jump_en); end
      end
      read_reg(5'd13, v);
      total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL ie_hold_pending got=%h exp=80000000", v); end
      mtc0(5'd12, 32'd1);
      total++; if (jump_en !== 1'b0) begin bad++; $display("FAIL ie_write_cycle got=%b exp=0", jump_en); end
      exe_valid = 1'b1;
      tick();
      total++; if (jump_en !== 1'b1 || jump_addr !== 32'h200) begin
         bad++; $display("FAIL ie_restored jump_en=%b addr=%h exp 1/200", jump_en, jump_addr);
      end
      tick();
      cp_oper = 2'd3; tick(); cp_oper = 2'd0; tick();
      ir_in = 1'b0;
   endtask

   task automatic test_eret_vs_irq();
      logic [31:0] v;
      ir_en = 1'b0; exe_valid = 1'b0;
      tick(); tick(); tick();
      mtc0(5'd14, 32'h500);
      ir_in = 1'b1;
      tick(); tick(); tick(); tick();
      cp_oper = 2'd3; exe_valid = 1'b1; ir_en = 1'b1; ret_addr = 32'h70;
      tick();
      total++; if (jump_en !== 1'b1 || jump_addr !== 32'h500) begin
         bad++; $display("FAIL eret_wins jump_en=%b addr=%h exp 1/500", jump_en, jump_addr);
      end
      read_reg(5'd13, v);
      total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL eret_keeps_pending got=%h exp=80000000", v); end
      // MTC0 to EPC on the entry edge loses to the return-address capture
      cp_oper = 2'd2; addr_w = 5'd14; data_w = 32'hABC;
      tick();
      cp_oper = 2'd0;
      total++; if (jump_en !== 1'b1 || jump_addr !== 32'h200) begin
         bad++; $display("FAIL entry_after_eret jump_en=%b addr=%h exp 1/200", jump_en, jump_addr);
      end
      read_reg(5'd14, v);
      total++; if (v !== 32'h70) begin bad++; $display("FAIL epc_capture_wins got=%h exp=70", v); end
      tick();
      total++; if (ir_active !== 1'b1 || jump_en !== 1'b0) begin
         bad++; $display("FAIL service_state ir_active=%b jump_en=%b exp 1/0", ir_active, jump_en);
      end
   endtask

   task automatic test_reset_in_service();
      logic [31:0] v;
      ir_in = 1'b0;
      tick(); tick(); tick();
      ir_in = 1'b1;
      tick(); tick(); tick(); tick();
      read_reg(5'd13, v);
      total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL pre_reset_pending got=%h exp=80000000", v); end
      rst = 1'b1; ir_in = 1'b0;
      tick();
      rst = 1'b0;
      total++; if (ir_active !== 1'b0 || jump_en !== 1'b0 || jump_addr !== 32'd0) begin
         bad++; $display("FAIL rst_outputs ir_active=%b jump_en=%b addr=%h exp 0/0/0", ir_active, jump_en, jump_addr);
      end
      read_reg(5'd25, v);
      total++; if (v !== 32'h100) begin bad++; $display("FAIL rst_ehbr got=%h exp=100", v); end
      read_reg(5'd13, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL rst_pending got=%h exp=0", v); end
      read_reg(5'd12, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL rst_status got=%h exp=0", v); end
   endtask

   initial begin
      test_reset();
      test_cp0_rw();
      test_entry();
      test_nested_and_eret();
      test_defer();
      test_ie_clear();
      test_eret_vs_irq();
      test_reset_in_service();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
